// File: rtl/md_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_pkg
// Description : Shared CPU definitions for the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package md_unit_pkg;

   localparam int MD_STEPS = 32;
   localparam int MD_CNT_W = 5;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } md_state_e;

   function automatic logic md_op_is_signed(input logic [1:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

   function automatic logic md_op_is_div(input logic [1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/md_unit_step.sv
`default_nettype none
// ============================================================================
// Module      : md_step
// Description : One combinational iteration of shift-add multiply or
//               restoring divide on magnitude operands.
// Revision    : 1.0 - initial release
// ============================================================================
module md_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] opr,
   input  logic [WIDTH-1:0] opd,
   output logic [WIDTH-1:0] acc_next,
   output logic [WIDTH-1:0] opr_next,
   output logic             q_bit
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_trial;
   logic [WIDTH:0] w_diff;

   always_comb begin
      w_sum    = {1'b0, acc} + {1'b0, opd};
      w_trial  = {acc, opr[WIDTH-1]};
      w_diff   = w_trial - {1'b0, opd};
      q_bit    = 1'b0;
      acc_next = acc;
      opr_next = opr;
      if (is_div) begin
         // A clear borrow bit means the trial remainder covers the divisor.
         // The quotient LSB of opr_next is left zero; the caller inserts q_bit.
         q_bit    = ~w_diff[WIDTH];
         acc_next = q_bit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
         opr_next = {opr[WIDTH-2:0], 1'b0};
      end else if (opr[0]) begin
         acc_next = w_sum[WIDTH:1];
         opr_next = {w_sum[0], opr[WIDTH-1:1]};
      end else begin
         acc_next = {1'b0, acc[WIDTH-1:1]};
         opr_next = {acc[0], opr[WIDTH-1:1]};
      end
   end

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : Iterative HI/LO multiply/divide unit with MTHI/MTLO, abort
//               and a fixed 33-cycle latency per operation.
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit
   import md_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   md_state_e             r_state;
   md_state_e             w_state_next;
   logic [MD_CNT_W-1:0]   r_cnt;
   logic                  r_is_div;
   logic                  r_neg_res;
   logic                  r_neg_rem;
   logic                  r_div_zero;
   logic [WIDTH-1:0]      r_acc;
   logic [WIDTH-1:0]      r_opr;
   logic [WIDTH-1:0]      r_opd;
   logic [WIDTH-1:0]      r_hi;
   logic [WIDTH-1:0]      r_lo;
   logic                  r_done;

   logic                  w_idle;
   logic                  w_accept;
   logic                  w_last_step;
   logic                  w_fix_commit;
   logic                  w_signed;
   logic [WIDTH-1:0]      w_abs_a;
   logic [WIDTH-1:0]      w_abs_b;
   logic [WIDTH-1:0]      w_acc_next;
   logic [WIDTH-1:0]      w_opr_next;
   logic                  w_q_bit;
   logic [2*WIDTH-1:0]    w_prod;
   logic [WIDTH-1:0]      w_fix_hi;
   logic [WIDTH-1:0]      w_fix_lo;

   assign w_idle       = (r_state == ST_IDLE);
   assign w_accept     = w_idle & start & ~abort;
   assign w_last_step  = (r_cnt == MD_CNT_W'(MD_STEPS - 1));
   assign w_fix_commit = (r_state == ST_FIX) & ~abort;
   assign w_signed     = md_op_is_signed(op);
   assign w_abs_a      = (w_signed & a[WIDTH-1]) ? -a : a;
   assign w_abs_b      = (w_signed & b[WIDTH-1]) ? -b : b;

   md_step #(
      .WIDTH    (WIDTH)
   ) u_step (
      .is_div   (r_is_div),
      .acc      (r_acc),
      .opr      (r_opr),
      .opd      (r_opd),
      .acc_next (w_acc_next),
      .opr_next (w_opr_next),
      .q_bit    (w_q_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_next = ST_CALC;
         ST_CALC: begin
            if (abort)            w_state_next = ST_IDLE;
            else if (w_last_step) w_state_next = ST_FIX;
         end
         ST_FIX:  w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Sign correction; a zero divisor yields all-ones quotient and the raw
   // dividend as remainder, which the remainder sign rule already produces.
   always_comb begin
      w_prod   = {r_acc, r_opr};
      w_fix_hi = r_acc;
      w_fix_lo = r_opr;
      if (!r_is_div) begin
         if (r_neg_res) w_prod = -w_prod;
         w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
         w_fix_lo = w_prod[WIDTH-1:0];
      end else begin
         w_fix_hi = r_neg_rem ? -r_acc : r_acc;
         if (r_div_zero)     w_fix_lo = '1;
         else if (r_neg_res) w_fix_lo = -r_opr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_is_div   <= 1'b0;
         r_neg_res  <= 1'b0;
         r_neg_rem  <= 1'b0;
         r_div_zero <= 1'b0;
         r_acc      <= '0;
         r_opr      <= '0;
         r_opd      <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= w_fix_commit;
         if (w_idle) begin
            if (w_accept) begin
               r_cnt      <= '0;
               r_is_div   <= md_op_is_div(op);
               r_neg_res  <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
               r_neg_rem  <= w_signed & a[WIDTH-1];
               r_div_zero <= (b == '0);
               r_acc      <= '0;
               r_opr      <= w_abs_a;
               r_opd      <= w_abs_b;
            end else if (!start) begin
               if (hi_we) r_hi <= wdata;
               if (lo_we) r_lo <= wdata;
            end
         end else if (r_state == ST_CALC) begin
            if (!abort) begin
               r_cnt <= r_cnt + 1'b1;
               r_acc <= w_acc_next;
               r_opr <= r_is_div ? {w_opr_next[WIDTH-1:1], w_q_bit} : w_opr_next;
            end
         end else if (w_fix_commit) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
         end
      end
   end

   assign busy = ~w_idle;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit
// Description : Self-checking bench for md_unit: directed vectors, random
//               operations against an arithmetic model, and control corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    op = 2'b00;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          hi_we = 1'b0;
   logic          lo_we = 1'b0;
   logic [W-1:0]  wdata = '0;
   logic          abort = 1'b0;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[9];

   md_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .abort (abort),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Architectural result {hi, lo} straight from the arithmetic definitions.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint          sx, sy, sq, sr;
      longint unsigned ux, uy;
      logic [63:0]     r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      case (o)
         2'b00: r = sx * sy;
         2'b01: r = ux * uy;
         2'b10: begin
            if (y == 0) r = {x, 32'hFFFF_FFFF};
            else begin
               sq = sx / sy;
               sr = sx % sy;
               r  = {sr[31:0], sq[31:0]};
            end
         end
         default: begin
            if (y == 0) r = {x, 32'hFFFF_FFFF};
            else        r = {x % y, x / y};
         end
      endcase
      return r;
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int bcyc, output int nd);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      tick;
      start = 1'b0;
      bcyc  = 0;
      nd    = 0;
      while (busy && bcyc < 100) begin
         bcyc++;
         tick;
         if (done) nd++;
      end
      tick;
      if (done) nd++;
   endtask

   initial begin
      int          bc;
      int          nd;
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      logic [63:0] exp;

      vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[4] = '{2'b11, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
      vecs[5] = '{2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
      vecs[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[7] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
      vecs[8] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};

      #2 rst = 1'b1;
      #1;
      check("reset_hi", {32'd0, hi}, 64'd0);
      check("reset_lo", {32'd0, lo}, 64'd0);
      check("reset_busy_done", {62'd0, busy, done}, 64'd0);
      tick;
      tick;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, bc, nd);
         check($sformatf("vec%0d_hilo", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
         check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd33);
         check($sformatf("vec%0d_done_pulses", i), 64'(nd), 64'd1);
      end

      for (int i = 0; i < 30; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 20));
            2: ra = 32'h8000_0000;
            3: rb = 32'hFFFF_FFFF;
            default: ;
         endcase
         exp = model(ro, ra, rb);
         run_op(ro, ra, rb, bc, nd);
         check($sformatf("rand%0d_op%0d_%h_%h", i, ro, ra, rb), {hi, lo}, exp);
         check($sformatf("rand%0d_done", i), 64'(nd), 64'd1);
      end

      // MTHI/MTLO then an aborted DIVU with ignored start and lo_we while busy.
      wdata = 32'h1234_5678; hi_we = 1'b1; tick; hi_we = 1'b0;
      check("mthi", {32'd0, hi}, {32'd0, 32'h1234_5678});
      wdata = 32'h0BAD_F00D; lo_we = 1'b1; tick; lo_we = 1'b0;
      check("mtlo", {32'd0, lo}, {32'd0, 32'h0BAD_F00D});
      op = 2'b11; a = 32'd9; b = 32'd4; start = 1'b1; tick; start = 1'b0;
      check("divu_started", {63'd0, busy}, 64'd1);
      repeat (4) tick;
      op = 2'b00; start = 1'b1; lo_we = 1'b1; wdata = 32'd0;
      tick;
      start = 1'b0; lo_we = 1'b0;
      check("busy_lo_we_ignored", {32'd0, lo}, {32'd0, 32'h0BAD_F00D});
      repeat (3) tick;
      abort = 1'b1; tick; abort = 1'b0;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_hilo", {hi, lo}, {32'h1234_5678, 32'h0BAD_F00D});
      nd = done ? 1 : 0;
      repeat (40) begin tick; if (done || busy) nd++; end
      check("abort_no_done", 64'(nd), 64'd0);
      check("abort_hilo_later", {hi, lo}, {32'h1234_5678, 32'h0BAD_F00D});

      // abort suppresses a simultaneous start in IDLE
      op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1; abort = 1'b1; tick;
      start = 1'b0; abort = 1'b0;
      check("abort_with_start", {63'd0, busy}, 64'd0);

      // start wins over a simultaneous MTLO
      wdata = 32'h0000_DEAD; start = 1'b1; lo_we = 1'b1; tick;
      start = 1'b0; lo_we = 1'b0;
      check("start_drops_mtlo", {32'd0, lo}, {32'd0, 32'h0BAD_F00D});
      check("start_over_mtlo_busy", {63'd0, busy}, 64'd1);
      bc = 0;
      while (busy && bc < 100) begin bc++; tick; end
      check("start_over_mtlo_result", {hi, lo}, {32'd0, 32'd15});

      // asynchronous reset in the middle of a MULT
      op = 2'b00; a = 32'hFFFF_FFFD; b = 32'd7; start = 1'b1; tick; start = 1'b0;
      repeat (4) tick;
      #2 rst = 1'b1;
      #1;
      check("midrst_hilo", {hi, lo}, 64'd0);
      check("midrst_busy_done", {62'd0, busy, done}, 64'd0);
      tick;
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      repeat (40) begin tick; if (done || busy) nd++; end
      check("midrst_no_done", 64'(nd), 64'd0);

      run_op(2'b01, 32'd6, 32'd7, bc, nd);
      check("post_rst_result", {hi, lo}, {32'd0, 32'd42});
      check("post_rst_busy_cycles", 64'(bc), 64'd33);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
